// File: rtl/pingpong_frame_buf_pkg.sv
// Shared types and width helper for the ping-pong frame buffer.
package pingpong_frame_buf_pkg;

    typedef enum logic [1:0] {
        B_EMPTY = 2'd0,
        B_FILL  = 2'd1,
        B_FULL  = 2'd2
    } bank_state_t;

    // Counter width for values 0..n-1, never narrower than one bit.
    function automatic int width_of(input int n);
        if (n <= 1) begin
            return 1;
        end else begin
            return $clog2(n);
        end
    endfunction

endpackage

// File: rtl/pingpong_frame_buf_ram.sv
// Two-bank simple dual-port RAM; the bank bit selects the upper or lower half,
// and the registered read port doubles as the stream output register.
module frame_bank_ram
    import pingpong_frame_buf_pkg::*;
#(
    parameter int DATA_W    = 20,
    parameter int FRAME_LEN = 30
) (
    input  logic                           clk,
    input  logic                           RST,
    input  logic                           i_we,
    input  logic                           i_wr_bank,
    input  logic [width_of(FRAME_LEN)-1:0] i_wr_addr,
    input  logic [DATA_W-1:0]              i_wdata,
    input  logic                           i_re,
    input  logic                           i_rd_bank,
    input  logic [width_of(FRAME_LEN)-1:0] i_rd_addr,
    output logic [DATA_W-1:0]              o_rdata
);
    localparam int DEPTH  = 2 * FRAME_LEN;
    localparam int RAM_AW = width_of(DEPTH);

    logic [DATA_W-1:0] r_mem [0:DEPTH-1];
    logic [DATA_W-1:0] r_rdata;
    logic [RAM_AW-1:0] w_waddr;
    logic [RAM_AW-1:0] w_raddr;

    assign w_waddr = (i_wr_bank ? RAM_AW'(FRAME_LEN) : '0) + RAM_AW'(i_wr_addr);
    assign w_raddr = (i_rd_bank ? RAM_AW'(FRAME_LEN) : '0) + RAM_AW'(i_rd_addr);
    assign o_rdata = r_rdata;

    // Write port: contents are not reset.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[w_waddr] <= i_wdata;
        end
    end

    // Read port: the output holds whenever no read is issued.
    always_ff @(posedge clk) begin
        if (RST) begin
            r_rdata <= '0;
        end else if (i_re) begin
            r_rdata <= r_mem[w_raddr];
        end
    end

endmodule

// File: rtl/pingpong_frame_buf.sv
// Double-buffered frame buffer: one bank fills from the input stream while the
// other replays its completed frame REPLAY times on the output stream.
module pingpong_frame_buf
    import pingpong_frame_buf_pkg::*;
#(
    parameter int DATA_W    = 20,
    parameter int FRAME_LEN = 30,
    parameter int REPLAY    = 1
) (
    input  logic              clk,
    input  logic              RST,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] datain,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] dataout,
    output logic              out_last,
    output logic [1:0]        full_banks
);
    localparam int ADDR_W = width_of(FRAME_LEN);
    localparam int PASS_W = width_of(REPLAY);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME_LEN - 1);
    localparam logic [PASS_W-1:0] LAST_PASS = PASS_W'(REPLAY - 1);

    bank_state_t       r_state [2];
    logic              r_wr_bank;
    logic [ADDR_W-1:0] r_wr_addr;
    logic              r_rd_bank;
    logic [ADDR_W-1:0] r_rd_addr;
    logic [PASS_W-1:0] r_pass;
    logic              r_out_valid;
    logic              r_out_last;

    logic              w_in_ready;
    logic              w_wr_acc;
    logic              w_wr_last;
    logic              w_rd_en;
    logic              w_rd_last_addr;
    logic              w_rd_done;
    logic [DATA_W-1:0] w_rdata;

    assign w_in_ready     = (r_state[r_wr_bank] != B_FULL);
    assign w_wr_acc       = in_valid && w_in_ready;
    assign w_wr_last      = (r_wr_addr == LAST_ADDR);
    assign w_rd_en        = (r_state[r_rd_bank] == B_FULL) && (!r_out_valid || out_ready);
    assign w_rd_last_addr = (r_rd_addr == LAST_ADDR);
    assign w_rd_done      = w_rd_en && w_rd_last_addr && (r_pass == LAST_PASS);

    assign in_ready   = w_in_ready;
    assign out_valid  = r_out_valid;
    assign out_last   = r_out_last;
    assign dataout    = w_rdata;
    assign full_banks = {r_state[1] == B_FULL, r_state[0] == B_FULL};

    // Write pointer: wraps at the frame end and hands over to the other bank.
    always_ff @(posedge clk) begin
        if (RST) begin
            r_wr_bank <= 1'b0;
            r_wr_addr <= '0;
        end else if (w_wr_acc) begin
            if (w_wr_last) begin
                r_wr_addr <= '0;
                r_wr_bank <= ~r_wr_bank;
            end else begin
                r_wr_addr <= r_wr_addr + ADDR_W'(1);
            end
        end
    end

    // Read pointer, pass counter and output flags.
    always_ff @(posedge clk) begin
        if (RST) begin
            r_rd_bank   <= 1'b0;
            r_rd_addr   <= '0;
            r_pass      <= '0;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
        end else begin
            if (w_rd_en) begin
                r_out_valid <= 1'b1;
                r_out_last  <= w_rd_last_addr;
                if (w_rd_last_addr) begin
                    r_rd_addr <= '0;
                    if (r_pass == LAST_PASS) begin
                        r_pass    <= '0;
                        r_rd_bank <= ~r_rd_bank;
                    end else begin
                        r_pass <= r_pass + PASS_W'(1);
                    end
                end else begin
                    r_rd_addr <= r_rd_addr + ADDR_W'(1);
                end
            end else if (out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    // Per-bank state: writer and reader never own the same bank at once.
    always_ff @(posedge clk) begin
        for (int b = 0; b < 2; b++) begin
            if (RST) begin
                r_state[b] <= B_EMPTY;
            end else begin
                case (r_state[b])
                    B_EMPTY: begin
                        if (w_wr_acc && (r_wr_bank == 1'(b))) begin
                            r_state[b] <= B_FILL;
                        end
                    end
                    B_FILL: begin
                        if (w_wr_acc && (r_wr_bank == 1'(b)) && w_wr_last) begin
                            r_state[b] <= B_FULL;
                        end
                    end
                    B_FULL: begin
                        if (w_rd_done && (r_rd_bank == 1'(b))) begin
                            r_state[b] <= B_EMPTY;
                        end
                    end
                    default: begin
                        r_state[b] <= B_EMPTY;
                    end
                endcase
            end
        end
    end

    frame_bank_ram #(
        .DATA_W    (DATA_W),
        .FRAME_LEN (FRAME_LEN)
    ) u_ram (
        .clk       (clk),
        .RST       (RST),
        .i_we      (w_wr_acc),
        .i_wr_bank (r_wr_bank),
        .i_wr_addr (r_wr_addr),
        .i_wdata   (datain),
        .i_re      (w_rd_en),
        .i_rd_bank (r_rd_bank),
        .i_rd_addr (r_rd_addr),
        .o_rdata   (w_rdata)
    );

endmodule

// File: tb/tb_pingpong_frame_buf.sv
// Bench for pingpong_frame_buf: three builds share one stimulus stream and are
// each checked every cycle against a frame-queue model; directed literals pin it.
module tb_pingpong_frame_buf;

    logic        clk = 1'b0;
    logic        RST = 1'b1;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [19:0] datain = 20'd0;

    logic [2:0]  rdy_a;
    logic [2:0]  ov_a;
    logic [2:0]  last_a;
    logic [1:0]  fb_a [3];
    logic [19:0] do_a [3];

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    always #5 clk = ~clk;

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        RST = 1'b1;
        in_valid = 1'b0;
        tick();
        RST = 1'b0;
    endtask

    task automatic wait_out(input string nm, input int exp);
        bit found;
        found = 1'b0;
        for (int c = 0; c < 200 && !found; c++) begin
            @(negedge clk);
            found = ov_a[0];
        end
        check({nm, " valid"}, found, 1);
        check({nm, " word0"}, do_a[0], exp);
    endtask

    // cfg0: defaults; cfg1: REPLAY=2; cfg2: FRAME_LEN=2, DATA_W=8.
    for (genvar g = 0; g < 3; g++) begin : g_cfg
        localparam int FL = (g == 2) ? 2 : 30;
        localparam int R  = (g == 1) ? 2 : 1;
        localparam int DW = (g == 2) ? 8 : 20;

        logic          w_rdy;
        logic          w_ov;
        logic          w_last;
        logic [DW-1:0] w_do;
        logic [1:0]    w_fb;

        pingpong_frame_buf #(
            .DATA_W    (DW),
            .FRAME_LEN (FL),
            .REPLAY    (R)
        ) u_dut (
            .clk        (clk),
            .RST        (RST),
            .in_valid   (in_valid),
            .in_ready   (w_rdy),
            .datain     (datain[DW-1:0]),
            .out_valid  (w_ov),
            .out_ready  (out_ready),
            .dataout    (w_do),
            .out_last   (w_last),
            .full_banks (w_fb)
        );

        assign rdy_a[g]  = w_rdy;
        assign ov_a[g]   = w_ov;
        assign last_a[g] = w_last;
        assign fb_a[g]   = w_fb;
        assign do_a[g]   = 20'(w_do);

        // Model: completed frames expand into a word queue (REPLAY copies);
        // held[] lists the bank of every frame whose final word is not yet issued.
        int av_d [$];
        bit av_l [$];
        bit av_e [$];
        int cur  [$];
        int held [$];
        int completed;
        bit m_valid, m_last, m_rdy;
        int m_data;

        initial begin
            bit acc;
            completed = 0;
            m_valid = 1'b0;
            m_last  = 1'b0;
            m_rdy   = 1'b1;
            m_data  = 0;
            forever begin
                @(posedge clk);
                if (RST) begin
                    av_d.delete(); av_l.delete(); av_e.delete();
                    cur.delete(); held.delete();
                    completed = 0;
                    m_valid = 1'b0; m_last = 1'b0; m_data = 0; m_rdy = 1'b1;
                end else begin
                    acc = in_valid && m_rdy;
                    if (av_d.size() > 0 && (!m_valid || out_ready)) begin
                        m_data  = av_d.pop_front();
                        m_last  = av_l.pop_front();
                        m_valid = 1'b1;
                        if (av_e.pop_front()) begin
                            void'(held.pop_front());
                        end
                    end else if (out_ready) begin
                        m_valid = 1'b0;
                    end
                    if (acc) begin
                        cur.push_back(int'(datain[DW-1:0]));
                        if (cur.size() == FL) begin
                            for (int r = 0; r < R; r++) begin
                                for (int i = 0; i < FL; i++) begin
                                    av_d.push_back(cur[i]);
                                    av_l.push_back(i == FL - 1);
                                    av_e.push_back((r == R - 1) && (i == FL - 1));
                                end
                            end
                            held.push_back(completed % 2);
                            completed++;
                            cur.delete();
                        end
                    end
                    m_rdy = (held.size() < 2);
                end
            end
        end

        initial begin
            logic [1:0] fbm;
            forever begin
                @(negedge clk);
                if (chk_en) begin
                    fbm = 2'b00;
                    foreach (held[i]) fbm[held[i]] = 1'b1;
                    check($sformatf("cfg%0d in_ready", g), w_rdy, m_rdy);
                    check($sformatf("cfg%0d out_valid", g), w_ov, m_valid);
                    check($sformatf("cfg%0d dataout", g), w_do, m_data);
                    check($sformatf("cfg%0d out_last", g), w_last, m_last);
                    check($sformatf("cfg%0d full_banks", g), w_fb, fbm);
                end
            end
        end
    end

    initial begin
        int acc;
        int nout;
        bit hs;

        RST = 1'b1;
        tick();
        chk_en = 1'b1;
        tick();
        RST = 1'b0;

        // Reset values.
        @(negedge clk);
        check("A in_ready", rdy_a[0], 1);
        check("A out_valid", ov_a[0], 0);
        check("A dataout", do_a[0], 0);
        check("A out_last", last_a[0], 0);
        check("A full_banks", fb_a[0], 0);

        // One frame 0..29, output free-running.
        out_ready = 1'b1;
        tick();
        for (int i = 0; i < 30; i++) begin
            in_valid = 1'b1;
            datain = 20'(i);
            tick();
        end
        in_valid = 1'b0;
        @(negedge clk);
        check("B full_banks cyc1", fb_a[0], 2'b01);
        check("B out_valid cyc1", ov_a[0], 0);
        @(negedge clk);
        check("B out_valid cyc2", ov_a[0], 1);
        check("B word0", do_a[0], 0);
        check("B last0", last_a[0], 0);
        for (int k = 1; k < 30; k++) begin
            @(negedge clk);
            check("B word", do_a[0], k);
            check("B last", last_a[0], (k == 29) ? 1 : 0);
        end
        @(negedge clk);
        check("B full_banks end", fb_a[0], 2'b00);
        check("B out_valid end", ov_a[0], 0);
        check("B replay pass2 valid", ov_a[1], 1);
        check("B replay pass2 word0", do_a[1], 0);
        check("B replay pass2 last", last_a[1], 0);
        check("B replay full_banks", fb_a[1], 2'b01);
        check("B replay in_ready", rdy_a[1], 1);

        // Three frames against a stalled output, then release.
        do_reset();
        out_ready = 1'b0;
        acc = 0;
        nout = 0;
        datain = 20'd1000;
        in_valid = 1'b1;
        for (int cyc = 0; cyc < 400 && nout < 90; cyc++) begin
            @(negedge clk);
            hs = in_valid && rdy_a[0];
            if (cyc == 68) begin
                check("C accepts before stall", acc, 60);
                check("C in_ready stalled", rdy_a[0], 0);
                check("C full_banks both", fb_a[0], 2'b11);
            end
            if (out_ready) begin
                if (nout > 0) check("C no gap", ov_a[0], 1);
                if (ov_a[0]) begin
                    check("C out word", do_a[0], 1000 + nout);
                    if (nout == 28) check("C in_ready before frame0 final", rdy_a[0], 0);
                    if (nout == 29) check("C in_ready after frame0 final", rdy_a[0], 1);
                    nout++;
                end
            end
            tick();
            if (hs) begin
                acc++;
                datain = 20'(1000 + acc);
                in_valid = (acc < 90);
            end
            if (cyc == 70) out_ready = 1'b1;
        end
        check("C words out", nout, 90);

        // Reset in the middle of a write frame.
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            in_valid = 1'b1;
            datain = 20'(500 + i);
            tick();
        end
        datain = 20'd512;
        RST = 1'b1;
        tick();
        RST = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        check("D1 out_valid", ov_a[0], 0);
        check("D1 in_ready", rdy_a[0], 1);
        check("D1 full_banks", fb_a[0], 0);
        tick();
        for (int i = 0; i < 30; i++) begin
            in_valid = 1'b1;
            datain = 20'(2000 + i);
            tick();
        end
        in_valid = 1'b0;
        wait_out("D1 next frame", 2000);

        // Reset while output word 7 is presented.
        do_reset();
        for (int i = 0; i < 30; i++) begin
            in_valid = 1'b1;
            datain = 20'(3000 + i);
            tick();
        end
        in_valid = 1'b0;
        wait_out("D2 frame", 3000);
        repeat (7) @(negedge clk);
        check("D2 word7", do_a[0], 3007);
        RST = 1'b1;
        tick();
        RST = 1'b0;
        @(negedge clk);
        check("D2 out_valid", ov_a[0], 0);
        check("D2 in_ready", rdy_a[0], 1);
        check("D2 dataout", do_a[0], 0);
        tick();
        for (int i = 0; i < 30; i++) begin
            in_valid = 1'b1;
            datain = 20'(4000 + i);
            tick();
        end
        in_valid = 1'b0;
        wait_out("D2 next frame", 4000);

        // Random traffic on both handshakes.
        do_reset();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 1) == 1);
            datain    = 20'($urandom_range(0, 20'hFFFFF));
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (300) tick();
        @(negedge clk);
        check("E drained cfg0", fb_a[0], 0);
        check("E drained cfg1", fb_a[1], 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pingpong_frame_buf.md
# pingpong_frame_buf

- Parametrised, double-buffered frame buffer for the NoC data-input path.
- Captures fixed-length frames of `FRAME_LEN` words from a valid/ready input stream into one of two banks.
- Replays each completed frame `REPLAY` times on a valid/ready output stream while the other bank fills.
- Sits between the input packetiser and the router injection port. Memory is inferred, not vendor IP.

## Interface
Parameters:
- `DATA_W`, 20, word width
- `FRAME_LEN`, 30, words per frame (≥2)
- `REPLAY`, 1, read-out passes per frame (≥1)

Ports:
- `clk`  in  1  single clock, all logic on rising edge
- `RST`  in  1  reset, synchronous, active-high
- `in_valid`  in  1  input word valid
- `in_ready`  out  1  buffer can accept; reset 1
- `datain`  in  DATA_W  input word
- `out_valid`  out  1  `dataout` valid; reset 0
- `out_ready`  in  1  downstream accepts
- `dataout`  out  DATA_W  output word; reset 0
- `out_last`  out  1  marks the final word of each pass; reset 0
- `full_banks`  out  2  per-bank FULL/DRAINING status; reset 0

## Operation
- Bank states are EMPTY, FILL, FULL.
  - EMPTY→FILL on the first accepted write.
  - FILL→FULL on the accepted write at `wr_addr==FRAME_LEN-1`.
  - FULL→EMPTY when the read for the final word of the final pass is issued.
- Write side:
  - Handshake is `in_valid && in_ready`.
  - `in_ready = state[wr_bank] != FULL`, from registered state only.
  - On each accept, the word goes to `wr_addr` and `wr_addr` increments.
  - At `FRAME_LEN-1`, `wr_addr` wraps to 0 and `wr_bank` toggles.
  - `in_valid` gaps are allowed anywhere.
- Read side:
  - Issue condition: `rd_en = state[rd_bank]==FULL && (!out_valid || out_ready)`.
  - The RAM read register is the output register, so `dataout` holds whenever `rd_en` is 0.
  - `rd_addr` runs 0..FRAME_LEN-1; `pass` runs 0..REPLAY-1.
  - At the final address of the final pass: `rd_addr` and `pass` go to 0 and `rd_bank` toggles.
- `out_valid` update:
  - Set after an edge with `rd_en`.
  - Cleared after an edge with `out_ready && !rd_en`.
- `out_last` is registered with the data; it is 1 when the issued address is `FRAME_LEN-1`, on every pass.
- Frames leave in arrival order, and banks alternate strictly.
- Boundary cases:
  - Both banks FULL: `in_ready=0`, and input is stalled without loss.
  - Final read issued in cycle k: that bank reads EMPTY in cycle k+1, so `in_ready` rises in k+1 if it is `wr_bank`. The other bank, if FULL, issues in k+1, with no bubble between frames.
  - A bank is never written and read in the same cycle (exclusive states).
  - `RST` asserted mid-frame: the partial frame is discarded. All pointers, `pass` and bank states clear, and outputs take their reset values after that edge. RAM contents are don't-care.
- Widths:
  - `ADDR_W = $clog2(FRAME_LEN)`, `PASS_W = max(1,$clog2(REPLAY))`.
  - Counters compare to the terminal value and never rely on natural overflow.

## Timing
- Latency: last input handshake in cycle 0 → bank FULL in cycle 1 → read issued in cycle 1 → `out_valid` and word 0 in cycle 2.
- Throughput: one word per cycle in and out sustained with `out_ready=1`. A frame drains in `FRAME_LEN*REPLAY` cycles.
- Backpressure takes effect in the same cycle; there is no skid and no combinational path from `in_valid` to `in_ready`.
- `out_ready` reaches the RAM read enable combinationally. This is the only input→output-register path.

## Structure
- `pingpong_frame_buf_pkg` holds:
  - the bank state enum (`B_EMPTY`, `B_FILL`, `B_FULL`)
  - the width helper function for `ADDR_W`/`PASS_W`
- Sub-module `frame_bank_ram`: simple dual-port RAM, `DEPTH=2*FRAME_LEN`.
  - Bank select is the address MSB segment (offset = bank*FRAME_LEN).
  - Synchronous read with a read-enable-gated output register that resets to 0.
- The top level holds both pointer/state machines and the output-valid logic.

## Test plan
- Default parameters, 30 words `datain=i`, `out_ready=1` → `dataout` 0..29 in cycles 2..31 after the last write; `out_last` only on 29; `full_banks` back to 0.
- `REPLAY=2`, one frame → 60 output words (0..29 twice); `out_last` on words 29 and 59; `in_ready` stays 1 throughout.
- Three frames pushed with `out_ready=0` → `in_ready` falls after 60 accepts; `full_banks=2'b11`. Raise `out_ready` → frame 0 comes out, `in_ready` rises the cycle after its final read issue, and frames 1 and 2 follow with no gap.
- Random `out_ready` and `in_valid` toggling over 20 frames → scoreboard matches in order; `dataout`/`out_last` are stable while `out_valid && !out_ready`.
- `RST` pulsed at write word 12, and separately at output word 7 → after the edge `out_valid=0`, `in_ready=1`; the next frame's output starts at its own word 0 with no stale data.
- `FRAME_LEN=2`, `DATA_W=8` corner build → alternating banks work; `out_last` on every second word.
